dvi_raster_gen: RTL and testbench

//  DVI raster generator: produces H/V sync, data-enable and a 24-bit pixel bus from a ready/valid pixel stream.

---
 rtl/dvi_raster_gen_if.sv | 12 +
 rtl/dvi_raster_gen.sv | 125 ++++++++++++
 tb/tb_dvi_raster_gen.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/dvi_raster_gen_if.sv
// Pixel stream between the image-buffer reader and the raster generator.
//   video : 24-bit pixel {R,G,B}, driven by the source
//   valid : video holds a valid pixel
//   ready : raster is in the active area; a pixel is taken when ready && valid
interface dvi_raster_gen_if;
   logic [23:0] video;
   logic        valid;
   logic        ready;

   modport master (output video, output valid, input ready);
   modport slave  (input video, input valid, output ready);
endinterface

// File: rtl/dvi_raster_gen.sv
// DVI raster generator.
// Walks a WIDTH x HEIGHT raster. It pulls pixels from a ready/valid stream during
// the active area and drives registered H/V sync, data-enable and a 24-bit pixel bus.
// A debounced pushbutton blanks the picture while it is held.
//   clk        pixel clock, rising edge
//   rst_n      asynchronous active-low reset
//   vid        pixel stream (slave side)
//   button     raw asynchronous pushbutton
//   db_enable  debouncer count enable
//   blank      debounced button
//   de, h, v   registered data-enable and active-high syncs
//   d          registered pixel to pins
//   underflow  sticky: an active pixel was needed while valid was low
module dvi_raster_gen #(
   parameter int WIDTH    = 1040,
   parameter int FRONT_H  = 56,
   parameter int PULSE_H  = 120,
   parameter int BACK_H   = 64,
   parameter int HEIGHT   = 666,
   parameter int FRONT_V  = 37,
   parameter int PULSE_V  = 6,
   parameter int BACK_V   = 23,
   parameter int DB_WIDTH = 20
) (
   input  logic                  clk,
   input  logic                  rst_n,
   dvi_raster_gen_if.slave       vid,
   input  logic                  button,
   input  logic                  db_enable,
   output logic                  blank,
   output logic                  de,
   output logic                  h,
   output logic                  v,
   output logic [23:0]           d,
   output logic                  underflow
);

   localparam int H_ACT = WIDTH - FRONT_H - PULSE_H - BACK_H;
   localparam int V_ACT = HEIGHT - FRONT_V - PULSE_V - BACK_V;
   localparam int HW    = $clog2(WIDTH);
   localparam int VW    = $clog2(HEIGHT);

   localparam logic [HW-1:0] H_LAST  = HW'(WIDTH - 1);
   localparam logic [HW-1:0] H_ACT_C = HW'(H_ACT);
   localparam logic [HW-1:0] HS_BEG  = HW'(H_ACT + FRONT_H);
   localparam logic [HW-1:0] HS_END  = HW'(H_ACT + FRONT_H + PULSE_H);
   localparam logic [VW-1:0] V_LAST  = VW'(HEIGHT - 1);
   localparam logic [VW-1:0] V_ACT_C = VW'(V_ACT);
   localparam logic [VW-1:0] VS_BEG  = VW'(V_ACT + FRONT_V);
   localparam logic [VW-1:0] VS_END  = VW'(V_ACT + FRONT_V + PULSE_V);

   localparam logic [DB_WIDTH-1:0] DB_MAX = '1;

   logic [HW-1:0]       hcount;
   logic [VW-1:0]       vcount;
   logic                active;
   logic                hsync;
   logic                vsync;
   logic                sync_a;
   logic                sync_s;
   logic [DB_WIDTH-1:0] db_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hcount <= '0;
         vcount <= '0;
      end else if (hcount == H_LAST) begin
         hcount <= '0;
         vcount <= (vcount == V_LAST) ? '0 : vcount + 1'b1;
      end else begin
         hcount <= hcount + 1'b1;
      end
   end

   always_comb begin
      active    = (hcount < H_ACT_C) && (vcount < V_ACT_C);
      hsync     = (hcount >= HS_BEG) && (hcount < HS_END);
      vsync     = (vcount >= VS_BEG) && (vcount < VS_END);
      vid.ready = active;
   end

   // Blanked pixels are still consumed by the ready/valid handshake, so the
   // stream stays aligned to the raster; only the pin data is forced to zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         de        <= 1'b0;
         h         <= 1'b0;
         v         <= 1'b0;
         d         <= '0;
         underflow <= 1'b0;
      end else begin
         de <= active;
         h  <= hsync;
         v  <= vsync;
         d  <= (active && vid.valid && !blank) ? vid.video : '0;
         if (active && !vid.valid)
            underflow <= 1'b1;
      end
   end

   // Debouncer: any disagreement between the synchronised button and blank
   // must persist for a full counter wrap before blank follows it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_a <= 1'b0;
         sync_s <= 1'b0;
         db_cnt <= '0;
         blank  <= 1'b0;
      end else begin
         sync_a <= button;
         sync_s <= sync_a;
         if (sync_s == blank) begin
            db_cnt <= '0;
         end else if (db_enable) begin
            if (db_cnt == DB_MAX) begin
               blank  <= sync_s;
               db_cnt <= '0;
            end else begin
               db_cnt <= db_cnt + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_dvi_raster_gen.sv
module tb_dvi_raster_gen;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        button = 1'b0;
   logic        db_enable = 1'b1;
   logic        blank, de, h, v, underflow;
   logic [23:0] d;

   int checks = 0;
   int failures = 0;
   int ecnt = 0;
   logic [23:0] pix = 24'd1;

   dvi_raster_gen_if vif ();

   dvi_raster_gen #(
      .WIDTH(10), .FRONT_H(1), .PULSE_H(2), .BACK_H(1),
      .HEIGHT(6), .FRONT_V(1), .PULSE_V(1), .BACK_V(1),
      .DB_WIDTH(3)
   ) dut (
      .clk(clk), .rst_n(rst_n), .vid(vif),
      .button(button), .db_enable(db_enable),
      .blank(blank), .de(de), .h(h), .v(v), .d(d), .underflow(underflow)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h (edge %0d)", tag, got, exp, ecnt);
      end
   endtask

   // One clock; the source advances to the next pixel when one was taken.
   task automatic step();
      logic taken;
      taken = rst_n && vif.ready && vif.valid;
      @(posedge clk);
      #1;
      ecnt++;
      if (taken) pix = pix + 24'd1;
      vif.video = pix;
   endtask

   // Outputs after edge k reflect the counters as they stood before it.
   function automatic int hc_of(input int k); return ((k - 1) % 60) % 10; endfunction
   function automatic int vc_of(input int k); return ((k - 1) % 60) / 10; endfunction
   function automatic logic e_de(input int k); return hc_of(k) < 6 && vc_of(k) < 3; endfunction
   function automatic logic e_h(input int k);  return hc_of(k) == 7 || hc_of(k) == 8; endfunction
   function automatic logic e_v(input int k);  return vc_of(k) == 4; endfunction
   function automatic logic [31:0] e_d(input int k);
      return e_de(k) ? 32'(vc_of(k) * 6 + hc_of(k) + 1) : 32'd0;
   endfunction

   initial begin
      int de_total;
      int h_total;
      vif.video = 24'd1;
      vif.valid = 1'b1;

      repeat (3) @(posedge clk);
      #1;
      check_val("rst_de", de, 0);
      check_val("rst_h", h, 0);
      check_val("rst_v", v, 0);
      check_val("rst_d", d, 0);
      check_val("rst_blank", blank, 0);
      check_val("rst_underflow", underflow, 0);
      check_val("rst_ready", vif.ready, 1);

      rst_n = 1'b1;
      de_total = 0;
      h_total = 0;
      for (int k = 1; k <= 60; k++) begin
         step();
         check_val("f1_de", de, e_de(ecnt));
         check_val("f1_h", h, e_h(ecnt));
         check_val("f1_v", v, e_v(ecnt));
         check_val("f1_d", d, e_d(ecnt));
         de_total += de;
         h_total += h;
      end
      check_val("f1_de_total", de_total, 18);
      check_val("f1_h_total", h_total, 12);
      check_val("f1_underflow", underflow, 0);

      vif.valid = 1'b0;
      step();
      check_val("uf_de", de, 1);
      check_val("uf_d", d, 0);
      check_val("uf_flag", underflow, 1);
      vif.valid = 1'b1;
      step();
      check_val("uf_next_d", d, 19);
      repeat (60) step();
      check_val("uf_sticky", underflow, 1);

      button = 1'b1;
      repeat (9) step();
      check_val("blank_early", blank, 0);
      step();
      check_val("blank_set", blank, 1);
      for (int k = 0; k < 60; k++) begin
         step();
         check_val("blank_de", de, e_de(ecnt));
         check_val("blank_d", d, 0);
      end
      button = 1'b0;
      repeat (9) step();
      check_val("unblank_early", blank, 1);
      step();
      check_val("unblank", blank, 0);

      button = 1'b1;
      repeat (4) step();
      button = 1'b0;
      repeat (8) step();
      check_val("glitch", blank, 0);

      button = 1'b1;
      repeat (5) step();
      db_enable = 1'b0;
      repeat (4) step();
      db_enable = 1'b1;
      repeat (4) step();
      check_val("frozen_early", blank, 0);
      step();
      check_val("frozen_set", blank, 1);
      button = 1'b0;
      repeat (10) step();
      check_val("frozen_clear", blank, 0);

      for (int k = 0; k < 60 && (ecnt % 60) != 3; k++) step();
      check_val("mid_de", de, e_de(ecnt));
      rst_n = 1'b0;
      #1;
      check_val("arst_de", de, 0);
      check_val("arst_d", d, 0);
      check_val("arst_underflow", underflow, 0);
      check_val("arst_ready", vif.ready, 1);
      repeat (2) @(posedge clk);
      #1;
      ecnt = 0;
      pix = 24'd1;
      vif.video = pix;
      rst_n = 1'b1;
      for (int k = 1; k <= 12; k++) begin
         step();
         check_val("restart_de", de, e_de(ecnt));
         check_val("restart_h", h, e_h(ecnt));
         check_val("restart_d", d, e_d(ecnt));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
